pool_stream_driver: RTL and testbench

//  Host-side partner of the ReLU/max-pool engine. Buffers one frame of signed samples written by the host,

---
 rtl/pool_stream_pkg.sv | 11 +
 rtl/relu_max_ref.sv | 63 ++++++
 rtl/pool_stream_driver.sv | 169 ++++++++++++++++
 tb/tb_pool_stream_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pool_stream_pkg.sv
// Shared types and sizing for the pooling-engine stream driver.
package pool_stream_pkg;
  localparam int DATA_W    = 4;
  localparam int FRAME_LEN = 20;
  localparam int POOL_WIN  = 4;
  localparam int RES_LEN   = FRAME_LEN / POOL_WIN;
  localparam int TIMEOUT   = 16;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, RECV} state_t;
endpackage

// File: rtl/relu_max_ref.sv
// Golden relu-max per POOL_WIN window of the outgoing sample stream, window 0 first.
// Used by pool_stream_driver only when POOL_SELF_CHECK_EN is defined.
module relu_max_ref
  import pool_stream_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr,
  input  logic    in_valid,
  input  sample_t in_data,
  output sample_t exp_o [RES_LEN]
);
  localparam int PW_W = $clog2(POOL_WIN);
  localparam int WI_W = $clog2(RES_LEN + 1);

  logic [PW_W-1:0] pos_q, pos_d;
  logic [WI_W-1:0] win_q, win_d;
  sample_t acc_q, acc_d, cand;
  sample_t exp_q [RES_LEN];
  sample_t exp_d [RES_LEN];

  always_comb begin
    pos_d = pos_q;
    win_d = win_q;
    acc_d = acc_q;
    exp_d = exp_q;
    // each window starts from 0, which folds the relu into the running max
    cand  = (pos_q == '0) ? '0 : acc_q;
    if (clr) begin
      pos_d = '0;
      win_d = '0;
      acc_d = '0;
      for (int i = 0; i < RES_LEN; i++) exp_d[i] = '0;
    end else if (in_valid) begin
      acc_d = (in_data > cand) ? in_data : cand;
      if (pos_q == PW_W'(POOL_WIN - 1)) begin
        pos_d = '0;
        if (win_q < WI_W'(RES_LEN)) begin
          exp_d[win_q[$clog2(RES_LEN)-1:0]] = acc_d;
          win_d = win_q + 1'b1;
        end
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      win_q <= '0;
      acc_q <= '0;
      for (int i = 0; i < RES_LEN; i++) exp_q[i] <= '0;
    end else begin
      pos_q <= pos_d;
      win_q <= win_d;
      acc_q <= acc_d;
      exp_q <= exp_d;
    end
  end

  assign exp_o = exp_q;
endmodule

// File: rtl/pool_stream_driver.sv
// Frame buffer -> serial burst to the pooling engine -> captured result buffer, with rx timeout.
// Optional golden self-check of the returned results when POOL_SELF_CHECK_EN is defined.
module pool_stream_driver
  import pool_stream_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [4:0]               wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     mismatch,
  input  logic [2:0]               rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     tx_valid,
  output logic signed [DATA_W-1:0] tx_data,
  input  logic                     rx_valid,
  input  logic signed [DATA_W-1:0] rx_data
);
  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam int RC_W  = $clog2(RES_LEN);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  sample_t frame_q [FRAME_LEN];
  sample_t frame_d [FRAME_LEN];
  sample_t result_q [RES_LEN];
  sample_t result_d [RES_LEN];
  logic    tx_valid_q, tx_valid_d;
  sample_t tx_data_q, tx_data_d;
  logic    done_q, done_d;
  logic    err_q, err_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rcnt_d     = rcnt_q;
    tcnt_d     = tcnt_q;
    frame_d    = frame_q;
    result_d   = result_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (state_q == IDLE && wr_en && wr_addr < 5'(FRAME_LEN)) frame_d[wr_addr] = wr_data;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SEND;
          err_d      = 1'b0;
          for (int i = 0; i < RES_LEN; i++) result_d[i] = '0;
          tx_valid_d = 1'b1;
          // frame_d so a write landing with start is what goes out first
          tx_data_d  = frame_d[0];
          idx_d      = IDX_W'(1);
        end
      end
      SEND: begin
        if (idx_q == IDX_W'(FRAME_LEN)) begin
          state_d    = WAIT;
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          rcnt_d     = '0;
          tcnt_d     = '0;
        end else begin
          tx_data_d = frame_q[idx_q];
          idx_d     = idx_q + 1'b1;
        end
      end
      WAIT, RECV: begin
        if (rx_valid) begin
          result_d[rcnt_q] = rx_data;
          tcnt_d = '0;
          if (rcnt_q == RC_W'(RES_LEN - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RECV;
            rcnt_d  = rcnt_q + 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_d == TO_W'(TIMEOUT)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rcnt_q     <= '0;
      tcnt_q     <= '0;
      for (int i = 0; i < FRAME_LEN; i++) frame_q[i] <= '0;
      for (int i = 0; i < RES_LEN; i++) result_q[i] <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rcnt_q     <= rcnt_d;
      tcnt_q     <= tcnt_d;
      frame_q    <= frame_d;
      result_q   <= result_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef POOL_SELF_CHECK_EN
  sample_t exp_w [RES_LEN];
  logic    start_acc;
  logic    mismatch_q, mismatch_d;

  assign start_acc = (state_q == IDLE) && start;

  relu_max_ref u_ref (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_acc),
    .in_valid (tx_valid_q),
    .in_data  (tx_data_q),
    .exp_o    (exp_w)
  );

  always_comb begin
    mismatch_d = mismatch_q;
    if (start_acc) begin
      mismatch_d = 1'b0;
    end else if (done_d) begin
      for (int i = 0; i < RES_LEN; i++)
        if (result_d[i] != exp_w[i]) mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch_q <= 1'b0;
    else        mismatch_q <= mismatch_d;
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign rd_data  = (rd_addr < 3'(RES_LEN)) ? result_q[rd_addr] : '0;
endmodule

// File: tb/tb_pool_stream_driver.sv
// Directed bench for pool_stream_driver: tx-beat scoreboard, result model, timeout and reset cases.
module tb_pool_stream_driver;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [4:0]        wr_addr = '0;
  logic signed [3:0] wr_data = '0;
  logic              start = 1'b0;
  logic              busy, done, err, mismatch;
  logic [2:0]        rd_addr = '0;
  logic signed [3:0] rd_data;
  logic              tx_valid;
  logic signed [3:0] tx_data;
  logic              rx_valid = 1'b0;
  logic signed [3:0] rx_data = '0;

  int checks = 0;
  int errors = 0;
  int fm [20];
  int rm [5];
  int rsp [5];
  int txq [$];
  int f1 [20] = '{-3, 2, 5, -1, 1, 1, 1, 1, -8, -2, -1, -4, 7, 0, 3, 6, 4, -5, 2, 4};

  always #10 clk = ~clk;

  pool_stream_driver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mismatch (mismatch),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  function automatic int golden(input int w);
    int m = 0;
    for (int j = 0; j < 4; j++) if (fm[w*4+j] > m) m = fm[w*4+j];
    return m;
  endfunction

  task automatic write_frame(input int vals [20]);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 4'(vals[i]);
      @(posedge clk); @(negedge clk);
      fm[i] = vals[i];
    end
    wr_en = 1'b0;
  endtask

  task automatic run_send(input int inject_at, input int rst_at, input bit do_wr0, input int wr0_val);
    int exp_d;
    start = 1'b1;
    if (do_wr0) begin
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 4'(wr0_val); fm[0] = wr0_val;
    end
    for (int i = 0; i < 20; i++) txq.push_back(fm[i]);
    for (int i = 0; i < 5; i++) rm[i] = 0;
    @(posedge clk); @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check("busy_send", busy, 1);
    check("err_clr", err, 0);
    check("mm_clr", mismatch, 0);
    for (int b = 0; b < 20; b++) begin
      if (b == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("tx_valid_rst", tx_valid, 0);
        check("busy_rst", busy, 0);
        txq.delete();
        for (int i = 0; i < 20; i++) fm[i] = 0;
        for (int i = 0; i < 5; i++) rm[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check("tx_valid", tx_valid, 1);
      exp_d = (txq.size() > 0) ? txq.pop_front() : 99;
      check("tx_data", tx_data, exp_d);
      if (b == inject_at) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 4'sd2;
      end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
    end
    check("tx_valid_end", tx_valid, 0);
    check("tx_data_end", tx_data, 0);
    check("busy_wait", busy, 1);
  endtask

  task automatic respond(input int gap, input int extra, input int nb);
    bit mm_exp = 1'b0;
`ifdef POOL_SELF_CHECK_EN
    for (int i = 0; i < 5; i++) if (rsp[i] != golden(i)) mm_exp = 1'b1;
`endif
    for (int i = 0; i < nb; i++) begin
      rx_valid = 1'b1; rx_data = 4'(rsp[i]); rm[i] = rsp[i];
      @(negedge clk);
      rx_valid = 1'b0;
      check("done", done, (i == 4));
      check("err_rx", err, 0);
      if (i == 4) check("mismatch", mismatch, mm_exp);
      else if (i < nb - 1) repeat (gap) @(negedge clk);
    end
    if (nb == 5) begin
      @(negedge clk);
      check("done_pulse", done, 0);
      check("busy_done", busy, 0);
      check("mm_hold", mismatch, mm_exp);
      for (int e = 0; e < extra; e++) begin
        rx_valid = 1'b1; rx_data = -4'sd7;
        @(negedge clk);
        rx_valid = 1'b0;
        check("done_extra", done, 0);
        check("err_extra", err, 0);
      end
    end
  endtask

  task automatic timeout_wait();
    int n = -1;
    for (int c = 0; c < 40 && n < 0; c++) begin
      if (err === 1'b1) n = c;
      else begin
        check("done_silent", done, 0);
        @(negedge clk);
      end
    end
    check("timeout_cycles", n, 16);
    check("busy_abort", busy, 0);
  endtask

  task automatic readback();
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      check("rd_data", rd_data, (a < 5) ? rm[a % 5] : 0);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 20; i++) fm[i] = 0;
    for (int i = 0; i < 5; i++) rm[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mm", mismatch, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    readback();

    // basic transaction
    write_frame(f1);
    run_send(-1, -1, 1'b0, 0);
    rsp = '{5, 1, 0, 7, 4};
    respond(0, 0, 5);
    readback();

    // silent engine
    run_send(-1, -1, 1'b0, 0);
    timeout_wait();
    readback();

    // start and write while busy are ignored; frame[3] must stay -1 on the next send
    run_send(5, -1, 1'b0, 0);
    respond(0, 0, 5);
    readback();
    run_send(-1, -1, 1'b0, 0);
    respond(0, 0, 5);

    // reset mid-SEND clears everything
    run_send(-1, 10, 1'b0, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_err", err, 0);
    check("post_rst_tx", tx_valid, 0);
    readback();
    run_send(-1, -1, 1'b0, 0);
    rsp = '{0, 0, 0, 0, 0};
    respond(0, 0, 5);
    readback();

    // self-check: wrong then matching results
    write_frame(f1);
    run_send(-1, -1, 1'b0, 0);
    rsp = '{5, 1, 0, 7, 3};
    respond(0, 0, 5);
    readback();
    run_send(-1, -1, 1'b0, 0);
    rsp = '{5, 1, 0, 7, 4};
    respond(0, 0, 5);

    // gaps between beats and trailing extra beats
    run_send(-1, -1, 1'b0, 0);
    rsp = '{-2, 3, 6, -8, 1};
    respond(3, 2, 5);
    readback();

    // write to addr 0 in the start cycle goes out as beat 0
    run_send(-1, -1, 1'b1, 6);
    for (int i = 0; i < 5; i++) rsp[i] = golden(i);
    respond(0, 0, 5);
    readback();

    // partial results survive a timeout
    run_send(-1, -1, 1'b0, 0);
    rsp = '{2, -3, 0, 0, 0};
    respond(0, 0, 2);
    timeout_wait();
    readback();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
